// File: rtl/core_if_pkg.sv
// Shared definitions for the core-to-fabric interface blocks.
// Default widths and the store-buffer entry layout at those widths.
package core_if_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_age_match.sv
// Picks the youngest hit among buffered stores: rotate so wr_ptr-1 sits at the
// top index, priority-encode from the top, then rotate the one-hot back.
module sb_age_match #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] match,
    input  logic [PTR_W-1:0] wr_ptr,
    output logic [DEPTH-1:0] sel
);

    logic [DEPTH-1:0] hits;
    logic [DEPTH-1:0] rot;
    logic [DEPTH-1:0] onehot;
    logic             found;

    always_comb begin
        hits   = valid & match;
        rot    = '0;
        onehot = '0;
        sel    = '0;
        found  = 1'b0;
        // rot[DEPTH-1] is the slot just behind wr_ptr, i.e. the youngest store
        for (int i = 0; i < DEPTH; i++) begin
            rot[i] = hits[wr_ptr + PTR_W'(i)];
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rot[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel[wr_ptr + PTR_W'(i)] = onehot[i];
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core and the BRAM/peripheral fabric:
// in-order retirement, youngest-match store-to-load forwarding, sticky overflow.
module store_buffer
    import core_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 8,
    parameter bit FWD_EN = 1'b1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             enq_fire;

    // Handshake: a store transfers on enq_valid && enq_ready; a write retires
    // on mem_we. A full buffer never accepts, even while the head retires.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready;
    assign mem_we    = mem_grant && !empty;
    assign mem_addr  = entries[rd_ptr].addr;
    assign mem_data  = entries[rd_ptr].data;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Payload storage carries no reset; valid_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            entries[wr_ptr] <= '{addr: enq_addr, data: enq_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq_fire) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (mem_we) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (enq_fire && !mem_we) begin
                count_q <= count_q + 1'b1;
            end else if (mem_we && !enq_fire) begin
                count_q <= count_q - 1'b1;
            end
            if (enq_valid && full) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    generate
        if (FWD_EN) begin : g_fwd
            logic [DEPTH-1:0] match;
            logic [DEPTH-1:0] sel;

            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    match[i] = (entries[i].addr == ld_addr);
                end
            end

            sb_age_match #(.DEPTH(DEPTH)) u_age_match (
                .valid  (valid_q),
                .match  (match),
                .wr_ptr (wr_ptr),
                .sel    (sel)
            );

            always_comb begin
                ld_data = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (sel[i]) begin
                        ld_data = ld_data | entries[i].data;
                    end
                end
            end
            assign ld_hit = |sel;
        end else begin : g_no_fwd
            assign ld_hit  = 1'b0;
            assign ld_data = '0;
        end
    endgenerate

endmodule
